// File: rtl/qr_module_sampler_if.sv
// Sampler bus bundle: start/geometry inputs, frame-buffer read port, grid result.
// Latency: n/a (wiring only).
// Backpressure: none; the frame buffer must accept one read per cycle.
// Ports: centers_x/centers_y/mod_size/mod_size_valid (start side),
//        pixel_addr/read_en/pixel_in (frame-buffer side),
//        qr_grid/grid_valid/clipped/error_out/busy_out (result side).
interface qr_module_sampler_if #(
    parameter int GRID       = 21,
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT)
);
    logic [2:0][8:0]        centers_x;
    logic [2:0][8:0]        centers_y;
    logic [8:0]             mod_size;
    logic                   mod_size_valid;
    logic [ADDR_W-1:0]      pixel_addr;
    logic                   read_en;
    logic                   pixel_in;
    logic [GRID*GRID-1:0]   qr_grid;
    logic                   grid_valid;
    logic                   clipped;
    logic                   error_out;
    logic                   busy_out;

    // Sampler side.
    modport slave (
        input  centers_x, centers_y, mod_size, mod_size_valid, pixel_in,
        output pixel_addr, read_en, qr_grid, grid_valid, clipped, error_out, busy_out
    );

    // Upstream estimator / frame buffer / decoder side.
    modport master (
        output centers_x, centers_y, mod_size, mod_size_valid, pixel_in,
        input  pixel_addr, read_en, qr_grid, grid_valid, clipped, error_out, busy_out
    );
endinterface

// File: rtl/qr_module_sampler.sv
// Samples one frame-buffer pixel per QR module centre into a GRID x GRID bit grid.
// Latency: start -> grid_valid = GRID*GRID + 2 + READ_LATENCY cycles (2 for mod_size = 0).
// Backpressure: none; one read per cycle, starts ignored while busy.
// Ports: clk_in/rst_in (async active-high), bus (slave modport of qr_module_sampler_if).
module qr_module_sampler #(
    parameter int GRID         = 21,
    parameter int IMG_WIDTH    = 320,
    parameter int IMG_HEIGHT   = 240,
    parameter int READ_LATENCY = 2,
    parameter int ADDR_W       = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    qr_module_sampler_if.slave  bus
);
    localparam int CELLS = GRID * GRID;
    localparam int IDX_W = $clog2(CELLS);
    localparam int RC_W  = $clog2(GRID);
    localparam int DRN_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic signed [15:0] X_MAX    = 16'(IMG_WIDTH - 1);
    localparam logic signed [15:0] Y_MAX    = 16'(IMG_HEIGHT - 1);
    localparam logic [RC_W-1:0]    LAST_RC  = RC_W'(GRID - 1);
    localparam logic [DRN_W-1:0]   DRN_LAST = DRN_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [8:0]             cx_q, cy_q, mod_q;
    logic signed [15:0]     x0_q, x_q, y_q;
    logic [RC_W-1:0]        row_q, col_q;
    logic [IDX_W-1:0]       idx_q;
    logic [DRN_W-1:0]       drn_q;
    logic [READ_LATENCY-1:0] vld_sr;
    logic [IDX_W-1:0]       idx_sr [READ_LATENCY];
    logic [CELLS-1:0]       grid_q;
    logic                   clip_q, err_q;

    // Geometry helpers. Top-left finder centre is module (3,3), so the grid
    // origin sits three pitches up and left of it.
    logic signed [15:0] mod_s, cx_s, cy_s, org_x, org_y;
    logic               issue, last_read;
    logic               x_lo, x_hi, y_lo, y_hi, any_clamp;
    logic [15:0]        xc, yc;

    assign mod_s = $signed({7'd0, mod_q});
    assign cx_s  = $signed({7'd0, cx_q});
    assign cy_s  = $signed({7'd0, cy_q});
    assign org_x = cx_s - (mod_s + (mod_s <<< 1));
    assign org_y = cy_s - (mod_s + (mod_s <<< 1));

    assign issue     = (state == S_ISSUE);
    assign last_read = (row_q == LAST_RC) && (col_q == LAST_RC);

    assign x_lo = (x_q < 16'sd0);
    assign x_hi = (x_q > X_MAX);
    assign y_lo = (y_q < 16'sd0);
    assign y_hi = (y_q > Y_MAX);
    assign any_clamp = x_lo | x_hi | y_lo | y_hi;

    assign xc = x_lo ? 16'd0 : (x_hi ? $unsigned(X_MAX) : $unsigned(x_q));
    assign yc = y_lo ? 16'd0 : (y_hi ? $unsigned(Y_MAX) : $unsigned(y_q));

    // Address is forced to zero outside ISSUE so it only carries meaning
    // alongside read_en and reads zero out of reset.
    assign bus.pixel_addr = issue
        ? (ADDR_W'(yc) * ADDR_W'(IMG_WIDTH) + ADDR_W'(xc))
        : '0;
    assign bus.read_en    = issue;
    assign bus.qr_grid    = grid_q;
    assign bus.grid_valid = (state == S_DONE);
    assign bus.clipped    = clip_q;
    assign bus.error_out  = err_q;
    assign bus.busy_out   = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.mod_size_valid) state_nxt = S_SETUP;
            S_SETUP: state_nxt = (mod_q == 9'd0) ? S_DONE : S_ISSUE;
            S_ISSUE: if (last_read) state_nxt = S_DRAIN;
            S_DRAIN: if (drn_q == DRN_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latched geometry, incremental coordinate walk, in-flight
    // read tracking and result capture.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cx_q   <= '0;
            cy_q   <= '0;
            mod_q  <= '0;
            x0_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            row_q  <= '0;
            col_q  <= '0;
            idx_q  <= '0;
            drn_q  <= '0;
            vld_sr <= '0;
            for (int i = 0; i < READ_LATENCY; i++) idx_sr[i] <= '0;
            grid_q <= '0;
            clip_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            // Each read carries its grid index down the pipe so the data
            // lands in the right bit READ_LATENCY cycles later.
            vld_sr[0] <= issue;
            idx_sr[0] <= idx_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                idx_sr[i] <= idx_sr[i-1];
            end
            if (vld_sr[READ_LATENCY-1]) begin
                grid_q[idx_sr[READ_LATENCY-1]] <= bus.pixel_in;
            end

            case (state)
                S_IDLE: begin
                    if (bus.mod_size_valid) begin
                        cx_q   <= bus.centers_x[1];
                        cy_q   <= bus.centers_y[1];
                        mod_q  <= bus.mod_size;
                        grid_q <= '0;
                        clip_q <= 1'b0;
                        err_q  <= 1'b0;
                    end
                end
                S_SETUP: begin
                    if (mod_q == 9'd0) begin
                        err_q <= 1'b1;
                    end else begin
                        x0_q  <= org_x;
                        x_q   <= org_x;
                        y_q   <= org_y;
                        row_q <= '0;
                        col_q <= '0;
                        idx_q <= '0;
                    end
                end
                S_ISSUE: begin
                    drn_q <= '0;
                    if (any_clamp) clip_q <= 1'b1;
                    idx_q <= idx_q + 1'b1;
                    if (col_q == LAST_RC) begin
                        col_q <= '0;
                        x_q   <= x0_q;
                        row_q <= row_q + 1'b1;
                        y_q   <= y_q + mod_s;
                    end else begin
                        col_q <= col_q + 1'b1;
                        x_q   <= x_q + mod_s;
                    end
                end
                S_DRAIN: begin
                    drn_q <= drn_q + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_qr_module_sampler.sv
// Self-checking bench for qr_module_sampler: spec vectors, random geometry
// against an arithmetic reference model, zero-size, restart and async reset.
// Frame buffer is modelled as a 2-cycle read pipeline over a bit array.
module tb_qr_module_sampler;
    localparam int GRID  = 21;
    localparam int W     = 320;
    localparam int H     = 240;
    localparam int RL    = 2;
    localparam int AW    = $clog2(W * H);
    localparam int CELLS = GRID * GRID;
    localparam int GV_NOM = CELLS + 2 + RL;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    qr_module_sampler_if #(.GRID(GRID), .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW)) bus ();

    qr_module_sampler #(
        .GRID(GRID), .IMG_WIDTH(W), .IMG_HEIGHT(H), .READ_LATENCY(RL), .ADDR_W(AW)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    // Frame buffer: address sampled at the read edge, data presented two cycles later.
    bit   fb [W*H];
    logic rd_s1;
    always @(posedge clk) begin
        rd_s1        <= (bus.read_en === 1'b1) ? fb[bus.pixel_addr] : 1'b0;
        bus.pixel_in <= rd_s1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int addr; } rd_t;
    rd_t rd_q[$];
    int  gv_total = 0;

    always @(negedge clk) begin
        if (bus.read_en === 1'b1) rd_q.push_back(rd_t'{cyc, int'(bus.pixel_addr)});
        if (bus.grid_valid === 1'b1) gv_total++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic chk_grid(input string nm, input logic [CELLS-1:0] act, input logic [CELLS-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Reference model: direct per-module arithmetic from the grid geometry.
    int               m_addr [CELLS];
    bit               m_clip;
    logic [CELLS-1:0] m_grid;

    task automatic model(input int cx, input int cy, input int m);
        m_clip = 1'b0;
        m_grid = '0;
        for (int r = 0; r < GRID; r++) begin
            for (int c = 0; c < GRID; c++) begin
                int x, y;
                x = cx - 3 * m + c * m;
                y = cy - 3 * m + r * m;
                if (x < 0)      begin x = 0;     m_clip = 1'b1; end
                else if (x > W - 1) begin x = W - 1; m_clip = 1'b1; end
                if (y < 0)      begin y = 0;     m_clip = 1'b1; end
                else if (y > H - 1) begin y = H - 1; m_clip = 1'b1; end
                m_addr[r*GRID+c] = y * W + x;
                m_grid[r*GRID+c] = fb[y * W + x];
            end
        end
    endtask

    int start_cyc, rd_base, gv_base;

    task automatic start_run(input int cx, input int cy, input int m);
        @(posedge clk);
        #1;
        bus.centers_x      = {9'($urandom), 9'(cx), 9'($urandom)};
        bus.centers_y      = {9'($urandom), 9'(cy), 9'($urandom)};
        bus.mod_size       = 9'(m);
        bus.mod_size_valid = 1'b1;
        start_cyc = cyc;
        rd_base   = rd_q.size();
        gv_base   = gv_total;
        @(posedge clk);
        #1;
        bus.mod_size_valid = 1'b0;
        // Inputs are latched at start; scrambling them must not matter.
        bus.centers_x = {9'($urandom), 9'($urandom), 9'($urandom)};
        bus.centers_y = {9'($urandom), 9'($urandom), 9'($urandom)};
        bus.mod_size  = 9'($urandom);
    endtask

    // Returns at the falling edge of the grid_valid cycle (or after the budget).
    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.grid_valid !== 1'b1 && n < 2000);
    endtask

    task automatic check_done(input string tag, input int exp_gv, input bit exp_clip,
                              input bit exp_err, input int exp_reads);
        int n_rd, n_addr_bad, first_bad;
        n_rd = rd_q.size() - rd_base;
        chk({tag, " gv_cycle"}, cyc - start_cyc, exp_gv);
        chk({tag, " clipped"},  bus.clipped, exp_clip);
        chk({tag, " error_out"}, bus.error_out, exp_err);
        chk({tag, " busy_at_gv"}, bus.busy_out, 1);
        chk_grid({tag, " grid"}, bus.qr_grid, m_grid);
        chk({tag, " read_count"}, n_rd, exp_reads);
        if (exp_reads > 0) begin
            chk({tag, " first_read_cycle"}, (n_rd > 0) ? rd_q[rd_base].cyc - start_cyc : -1, 2);
            chk({tag, " last_read_cycle"}, (n_rd > 0) ? rd_q[rd_q.size()-1].cyc - start_cyc : -1,
                exp_reads + 1);
            n_addr_bad = 0;
            first_bad  = -1;
            for (int i = 0; i < CELLS && i < n_rd; i++) begin
                if (rd_q[rd_base+i].addr != m_addr[i]) begin
                    n_addr_bad++;
                    if (first_bad < 0) first_bad = i;
                end
            end
            if (first_bad >= 0)
                $display("  first wrong address at module %0d: got %0d required %0d",
                         first_bad, rd_q[rd_base+first_bad].addr, m_addr[first_bad]);
            chk({tag, " addr_seq_errors"}, n_addr_bad, 0);
        end
    endtask

    task automatic settle(input string tag);
        repeat (3) @(negedge clk);
        chk({tag, " busy_after"}, bus.busy_out, 0);
        chk({tag, " gv_after"}, bus.grid_valid, 0);
        chk({tag, " gv_pulses"}, gv_total - gv_base, 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " pixel_addr"}, bus.pixel_addr, 0);
        chk({tag, " read_en"},    bus.read_en, 0);
        chk({tag, " qr_grid_nz"}, (bus.qr_grid != '0) ? 1 : 0, 0);
        chk({tag, " grid_valid"}, bus.grid_valid, 0);
        chk({tag, " clipped"},    bus.clipped, 0);
        chk({tag, " error_out"},  bus.error_out, 0);
        chk({tag, " busy_out"},   bus.busy_out, 0);
    endtask

    typedef struct {
        int cx; int cy; int m;
        int r;  int c;  int addr;
        bit clip; bit grid_one;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int cx, cy, m, rd_mark, gv_mark, n;

        vecs[0] = '{100,  50, 4,  0,  0, 12248, 1'b0, 1'b1};
        vecs[1] = '{100,  50, 4,  0,  1, 12252, 1'b0, 1'b1};
        vecs[2] = '{100,  50, 4,  1,  0, 13528, 1'b0, 1'b1};
        vecs[3] = '{100,  50, 4, 20, 20, 37928, 1'b0, 1'b1};
        vecs[4] = '{  5,   5, 4,  0,  0,     0, 1'b1, 1'b0};
        vecs[5] = '{  5,   5, 4,  2,  2,   321, 1'b1, 1'b0};
        vecs[6] = '{310, 100, 8,  0, 20, 24639, 1'b1, 1'b0};

        rst = 1'b1;
        bus.mod_size_valid = 1'b0;
        bus.centers_x = '0;
        bus.centers_y = '0;
        bus.mod_size  = '0;
        for (int i = 0; i < W * H; i++) fb[i] = 1'b0;
        fb[12248] = 1'b1;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Spec vectors with a single dark pixel at 12248.
        for (int i = 0; i < 7; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            model(vecs[i].cx, vecs[i].cy, vecs[i].m);
            start_run(vecs[i].cx, vecs[i].cy, vecs[i].m);
            wait_done();
            check_done(tag, GV_NOM, vecs[i].clip, 1'b0, CELLS);
            chk({tag, " point_addr"},
                (rd_q.size() - rd_base > vecs[i].r * GRID + vecs[i].c)
                    ? rd_q[rd_base + vecs[i].r * GRID + vecs[i].c].addr : -1,
                vecs[i].addr);
            if (vecs[i].grid_one) chk_grid({tag, " grid_is_one"}, bus.qr_grid, CELLS'(1));
            settle(tag);
        end

        // Random frame content and geometry.
        for (int i = 0; i < W * H; i++) fb[i] = 1'($urandom);
        for (int k = 0; k < 4; k++) begin
            string tag;
            tag = $sformatf("rand%0d", k);
            cx = $urandom_range(0, W - 1);
            cy = $urandom_range(0, H - 1);
            m  = $urandom_range(1, 20);
            model(cx, cy, m);
            start_run(cx, cy, m);
            wait_done();
            check_done(tag, GV_NOM, m_clip, 1'b0, CELLS);
            settle(tag);
        end

        // Zero module size: immediate error, no reads, grid cleared.
        m_grid = '0;
        start_run(160, 120, 0);
        wait_done();
        check_done("zero", 2, 1'b0, 1'b1, 0);
        settle("zero");

        // Start pulse during ISSUE is ignored; start right after grid_valid is accepted.
        model(100, 50, 4);
        start_run(100, 50, 4);
        repeat (100) @(negedge clk);
        @(posedge clk);
        #1;
        bus.centers_x = {9'd7, 9'd200, 9'd9};
        bus.centers_y = {9'd7, 9'd150, 9'd9};
        bus.mod_size  = 9'd7;
        bus.mod_size_valid = 1'b1;
        @(posedge clk);
        #1 bus.mod_size_valid = 1'b0;
        wait_done();
        check_done("busy_ignore", GV_NOM, m_clip, 1'b0, CELLS);
        model(120, 80, 3);
        start_run(120, 80, 3);
        wait_done();
        check_done("restart", GV_NOM, m_clip, 1'b0, CELLS);
        settle("restart");

        // Asynchronous reset mid-ISSUE.
        start_run(150, 120, 5);
        n = 0;
        while (cyc - start_cyc < 200 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        #1 rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        rd_mark = rd_q.size();
        gv_mark = gv_total;
        #1 rst = 1'b0;
        repeat (460) @(negedge clk);
        chk("post_reset reads", rd_q.size() - rd_mark, 0);
        chk("post_reset gv_pulses", gv_total - gv_mark, 0);

        model(150, 120, 5);
        start_run(150, 120, 5);
        wait_done();
        check_done("after_reset", GV_NOM, m_clip, 1'b0, CELLS);
        settle("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/qr_module_sampler.md
# qr_module_sampler

Samples the QR symbol's module grid from the binarized frame buffer once the module size is known. It sits directly downstream of the module-size estimator. It consumes that block's `mod_size`/`mod_size_valid` pulse together with the finder-pattern centers, reads one pixel per module centre from frame-buffer BRAM, and produces a GRID×GRID bit grid for the decoder.

## Interface
- `GRID`, 21: modules per side (version-1 QR).
- `IMG_WIDTH`, 320: frame width in pixels.
- `IMG_HEIGHT`, 240: frame height in pixels.
- `READ_LATENCY`, 2: frame-buffer read latency in cycles.
- `ADDR_W`, $clog2(IMG_WIDTH*IMG_HEIGHT): pixel address width.
- `clk_in` input 1: system clock; the only clock.
- `rst_in` input 1: asynchronous, active-high reset.
- `centers_x[2:0]`, `centers_y[2:0]` input 9 each: finder centers; index 0 bottom-left, 1 top-left, 2 top-right. Only index 1 is used.
- `mod_size` input 9: module pitch in pixels.
- `mod_size_valid` input 1: one-cycle start pulse.
- `pixel_addr` output ADDR_W: frame-buffer read address.
- `read_en` output 1: read strobe.
- `pixel_in` input 1: read data; 1 = dark.
- `qr_grid` output GRID*GRID: bit r*GRID+c = module (row r, col c); row 0 is the top; 1 = dark.
- `grid_valid` output 1: one-cycle pulse; `qr_grid` is final.
- `clipped` output 1: at least one sample coordinate was clamped. Valid with `grid_valid`; held until next start.
- `error_out` output 1: `mod_size` was 0. Valid with `grid_valid`; held until next start.
- `busy_out` output 1: high whenever state ≠ IDLE.

## Operation
- States are IDLE, SETUP, ISSUE, DRAIN, DONE.
- IDLE → SETUP when `mod_size_valid`=1.
  - Latch `centers_x[1]`, `centers_y[1]` and `mod_size`.
  - Clear `qr_grid`, `clipped` and `error_out`.
  - `mod_size_valid` is ignored in every other state.
- SETUP, with latched mod_size = 0: set `error_out` and go to DONE. No reads are issued.
- SETUP, with mod_size ≠ 0:
  - Compute origin x0 = cx1 − 3·mod, y0 = cy1 − 3·mod; the top-left finder centre is module (3,3).
  - Initialise x = x0, y = y0, row = col = 0.
  - Go to ISSUE.
- x and y are 16-bit signed and advance incrementally; no general multiplier on the coordinates.
  - Each ISSUE cycle: col++ and x += mod.
  - At col = GRID−1: col = 0, x = x0, row++, y += mod.
- Clamping: xc = clamp(x, 0, IMG_WIDTH−1), yc = clamp(y, 0, IMG_HEIGHT−1). Any clamp sets `clipped` (sticky).
- Addressing: `pixel_addr` = yc·IMG_WIDTH + xc, a constant multiply. `pixel_addr` is combinational from the current x/y registers and is valid exactly while `read_en`=1.
- `read_en`=1 in every ISSUE cycle; reads go in raster order, row-major.
- After the read for (GRID−1, GRID−1), go to DRAIN.
- A READ_LATENCY-deep valid/index shift register tracks in-flight reads. `pixel_in` is written into `qr_grid[row*GRID+col]` READ_LATENCY cycles after its `read_en` cycle.
- DRAIN lasts READ_LATENCY cycles, then DONE.
- DONE: `grid_valid`=1 for one cycle, then IDLE.
- `qr_grid`, `clipped` and `error_out` hold until the next accepted start.
- Reset at any time, including mid-ISSUE or mid-DRAIN:
  - Immediately return to IDLE.
  - All outputs go to 0.
  - In-flight reads are discarded.

## Timing
- Reset values: `pixel_addr`=0, `read_en`=0, `qr_grid`=0, `grid_valid`=0, `clipped`=0, `error_out`=0, `busy_out`=0.
- Cycle 0: `mod_size_valid` high in IDLE.
- Cycle 1: SETUP; `busy_out`=1.
- Cycles 2 … GRID²+1: `read_en`=1. With the defaults this is cycles 2…442.
- Last capture: cycle GRID²+1+READ_LATENCY (444 with defaults).
- `grid_valid` pulse: cycle GRID²+2+READ_LATENCY (445 with defaults); `busy_out`=1 through that cycle.
- Next start is accepted the following cycle.
- mod_size = 0: `grid_valid` and `error_out` at cycle 2; `read_en` never asserts.
- Throughput is one module per cycle, with no stalls. The frame buffer must accept a read every cycle.

## Test plan
- Nominal sampling, setup: cx1=100, cy1=50, mod=4.
  - Required addresses: (0,0)=12248, (0,1)=12252, (1,0)=13528, (20,20)=37928.
  - Memory model returns 1 only for addr 12248.
  - Required result: `qr_grid` = 1 (bit 0 only), `clipped`=0, `grid_valid` at cycle 445.
- Low clamp: cx1=5, cy1=5, mod=4.
  - Required: (0,0) addr=0, (2,2) addr=1*320+1=321, `clipped`=1.
- High clamp: cx1=310, cy1=100, mod=8.
  - Required: col-20 x = 446 clamps to 319; (0,20) addr=76·320+319=24639; `clipped`=1.
- Zero size: mod=0.
  - Required: no `read_en`, `grid_valid`=1 and `error_out`=1 at cycle 2, `qr_grid`=0.
- Busy / restart:
  - Second `mod_size_valid` during ISSUE → ignored; exactly 441 reads, one `grid_valid`.
  - A new start the cycle after `grid_valid` → accepted.
- Async reset mid-operation:
  - `rst_in` pulsed at cycle 200 → all outputs 0 within the same cycle; no `grid_valid`.
  - A subsequent start completes normally.
